// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-side register engine: register indices, FSM states, palette mirroring.
// The DMA states exist only when PPU_OAM_DMA_EN is defined.
package ppu_pkg;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_MASK    = 3'd1,
    REG_STATUS  = 3'd2,
    REG_OAMADDR = 3'd3,
    REG_OAMDATA = 3'd4,
    REG_SCROLL  = 3'd5,
    REG_ADDR    = 3'd6,
    REG_DATA    = 3'd7
  } reg_idx_t;

`ifdef PPU_OAM_DMA_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VRD,
    ST_DMA_ALIGN,
    ST_DMA_RD,
    ST_DMA_WR
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_VRD
  } state_t;
`endif

  localparam int PAL_ENTRIES = 32;

  // Sprite backdrop slots $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
  function automatic logic [4:0] pal_mirror(input logic [4:0] idx);
    pal_mirror = (idx[4] && (idx[1:0] == 2'b00)) ? {1'b0, idx[3:0]} : idx;
  endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// 32-entry palette store: one synchronous write port, two combinational read ports (CPU and PPU).
// Mirroring is applied on every port so callers pass raw 5-bit indices.
module ppu_palette_ram
  import ppu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [PAL_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_ENTRIES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[pal_mirror(waddr)] <= wdata;
    end
  end

  assign rdata_a = mem[pal_mirror(raddr_a)];
  assign rdata_b = mem[pal_mirror(raddr_b)];

endmodule

// File: rtl/ppu_data_port.sv
// CPU-side PPU register engine: shared w latch, $2005/$2006/$2007, OAM pointer/data port.
// Optional $4014 OAM DMA engine built only when PPU_OAM_DMA_EN is defined.
module ppu_data_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int PAL_PAGE  = 'h3F,
  parameter int INC_ALT   = 32,
  parameter int OAM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_sel,
  input  logic [2:0]                   cpu_reg_sel,
  input  logic                         cpu_wr_en,
  input  logic                         cpu_rd_en,
  input  logic [DATA_W-1:0]            cpu_data_in,
  output logic [DATA_W-1:0]            cpu_data_out,
  input  logic                         status_read,
  input  logic                         inc_mode,
  output logic [DATA_W-1:0]            scroll_x,
  output logic [DATA_W-1:0]            scroll_y,
  output logic [ADDR_W-1:0]            vram_addr,
  output logic                         vram_wr_en,
  output logic                         vram_rd_en,
  output logic [DATA_W-1:0]            vram_wr_data,
  input  logic [DATA_W-1:0]            vram_rd_data,
  input  logic [4:0]                   ppu_pal_idx,
  output logic [DATA_W-1:0]            ppu_pal_data,
  output logic [$clog2(OAM_DEPTH)-1:0] oam_addr,
  output logic                         oam_wr_en,
  output logic [DATA_W-1:0]            oam_wr_data,
  input  logic                         dma_start,
  output logic [15:0]                  dma_addr,
  output logic                         dma_rd_en,
  input  logic [DATA_W-1:0]            dma_rd_data,
  output logic                         cpu_halt
);

  localparam int OAM_AW = $clog2(OAM_DEPTH);
  localparam int HI_W   = ADDR_W - 8;

  state_t            state, state_nx;
  logic              w;
  logic              w_eff;
  logic [HI_W-1:0]   addr_hi;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] pal_cpu_data;
  logic [ADDR_W-1:0] vram_step;
  logic              acc_ok, wr, rd, stat_rd;
  logic              wr_data, rd_data, wr_toggle;
  logic              is_pal, pal_we;

  assign acc_ok    = cpu_sel & ~cpu_halt;
  // A simultaneous write takes the cycle; the read is dropped.
  assign wr        = acc_ok & cpu_wr_en;
  assign rd        = acc_ok & cpu_rd_en & ~cpu_wr_en;
  assign stat_rd   = status_read & ~cpu_halt;
  assign wr_data   = wr & (cpu_reg_sel == REG_DATA);
  assign rd_data   = rd & (cpu_reg_sel == REG_DATA);
  assign wr_toggle = wr & ((cpu_reg_sel == REG_SCROLL) | (cpu_reg_sel == REG_ADDR));
  assign w_eff     = w & ~stat_rd;
  assign is_pal    = (vram_addr[ADDR_W-1:8] == PAL_PAGE[HI_W-1:0]);
  assign vram_step = inc_mode ? ADDR_W'(INC_ALT) : ADDR_W'(1);

`ifdef PPU_OAM_DMA_EN
  logic [7:0] dma_page;
  logic [7:0] dma_n;
  logic       dma_go;

  assign dma_go    = dma_start & ~cpu_halt;
  assign cpu_halt  = (state == ST_DMA_ALIGN) | (state == ST_DMA_RD) | (state == ST_DMA_WR);
  assign dma_rd_en = (state == ST_DMA_RD);
  assign dma_addr  = cpu_halt ? {dma_page, dma_n} : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_page <= '0;
      dma_n    <= '0;
    end else if (dma_go) begin
      dma_page <= cpu_data_in[7:0];
      dma_n    <= '0;
    end else if (state == ST_DMA_WR) begin
      dma_n <= dma_n + 8'd1;
    end
  end
`else
  logic unused_dma;

  assign unused_dma = ^{dma_start, dma_rd_data};
  assign cpu_halt   = 1'b0;
  assign dma_rd_en  = 1'b0;
  assign dma_addr   = 16'h0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    vram_wr_en   = 1'b0;
    vram_rd_en   = 1'b0;
    vram_wr_data = '0;
    pal_we       = 1'b0;
    oam_wr_en    = 1'b0;
    oam_wr_data  = '0;

    if (wr_data) begin
      if (is_pal) begin
        pal_we = 1'b1;
      end else begin
        vram_wr_en   = 1'b1;
        vram_wr_data = cpu_data_in;
      end
    end
    // Palette reads still fetch VRAM so the buffer tracks the address.
    if (rd_data) vram_rd_en = 1'b1;
    if (wr && (cpu_reg_sel == REG_OAMDATA)) begin
      oam_wr_en   = 1'b1;
      oam_wr_data = cpu_data_in;
    end

    case (state)
      ST_IDLE, ST_VRD: begin
        state_nx = rd_data ? ST_VRD : ST_IDLE;
`ifdef PPU_OAM_DMA_EN
        if (dma_go) state_nx = ST_DMA_ALIGN;
`endif
      end
`ifdef PPU_OAM_DMA_EN
      ST_DMA_ALIGN: state_nx = ST_DMA_RD;
      ST_DMA_RD:    state_nx = ST_DMA_WR;
      ST_DMA_WR: begin
        oam_wr_en   = 1'b1;
        oam_wr_data = dma_rd_data;
        state_nx    = (dma_n == 8'hFF) ? ST_IDLE : ST_DMA_RD;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w            <= 1'b0;
      addr_hi      <= '0;
      vram_addr    <= '0;
      scroll_x     <= '0;
      scroll_y     <= '0;
      rd_buf       <= '0;
      cpu_data_out <= '0;
      oam_addr     <= '0;
    end else begin
      w <= wr_toggle ? ~w_eff : w_eff;

      if (wr && (cpu_reg_sel == REG_SCROLL)) begin
        if (!w_eff) scroll_x <= cpu_data_in;
        else        scroll_y <= cpu_data_in;
      end

      if (wr && (cpu_reg_sel == REG_ADDR)) begin
        if (!w_eff) addr_hi   <= cpu_data_in[HI_W-1:0];
        else        vram_addr <= {addr_hi, cpu_data_in[7:0]};
      end else if (wr_data || rd_data) begin
        vram_addr <= vram_addr + vram_step;
      end

      if (state == ST_VRD) rd_buf <= vram_rd_data;

      // A read landing in the fill cycle takes the arriving byte, not the stale buffer.
      if (rd_data) begin
        if (is_pal)                cpu_data_out <= pal_cpu_data;
        else if (state == ST_VRD)  cpu_data_out <= vram_rd_data;
        else                       cpu_data_out <= rd_buf;
      end

      if (wr && (cpu_reg_sel == REG_OAMADDR)) oam_addr <= OAM_AW'(cpu_data_in);
      else if (oam_wr_en)                     oam_addr <= oam_addr + OAM_AW'(1);
    end
  end

  ppu_palette_ram #(
    .DATA_W (DATA_W)
  ) u_pal (
    .clk     (clk),
    .rst     (rst),
    .we      (pal_we),
    .waddr   (vram_addr[4:0]),
    .wdata   (cpu_data_in),
    .raddr_a (vram_addr[4:0]),
    .rdata_a (pal_cpu_data),
    .raddr_b (ppu_pal_idx),
    .rdata_b (ppu_pal_data)
  );

endmodule
